// File: rtl/disp_fmt_if.sv
// Handshake and digit bus between the value producer and disp_fmt.
// The producer drives start/value; disp_fmt returns status and the four display codes.
interface disp_fmt_if #(
    parameter int WIDTH = 15
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [4:0]       dig3;
    logic [4:0]       dig2;
    logic [4:0]       dig1;
    logic [4:0]       dig0;

    modport master (
        output start, value,
        input  busy, done, dig3, dig2, dig1, dig0
    );

    modport slave (
        input  start, value,
        output busy, done, dig3, dig2, dig1, dig0
    );
endinterface

// File: rtl/disp_fmt.sv
// Signed binary to four seven-segment display codes: iterative double-dabble,
// leading-zero blanking, minus-sign placement and overflow ("OFL") indication.
module disp_fmt #(
    parameter int WIDTH = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_fmt_if.slave   bus
);
    localparam logic [4:0] BCD_BLANK = 5'h10;
    localparam logic [4:0] BCD_NEG   = 5'h11;
    localparam logic [4:0] BCD_O     = 5'h12;
    localparam logic [4:0] BCD_F     = 5'h13;
    localparam logic [4:0] BCD_L     = 5'h14;

    typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [4:0]       dig_q [4];
    logic [4:0]       dig_d [4];

    logic [15:0]      bcd_adj;
    logic [4:0]       fmt_dig [4];
    logic [1:0]       msd;
    logic             in_sign;
    logic [WIDTH-1:0] abs_val;
    logic [15:0]      abs_ext;

    // Negating the most negative input wraps to 2^(WIDTH-1), which is exact as unsigned.
    assign in_sign = bus.value[WIDTH-1];
    assign abs_val = in_sign ? -bus.value : bus.value;
    assign abs_ext = 16'(abs_val);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        fmt_dig = '{default: BCD_BLANK};
        msd     = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) msd = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > int'(msd)) fmt_dig[i] = BCD_BLANK;
            else               fmt_dig[i] = {1'b0, bcd_q[i*4 +: 4]};
        end
        // A non-overflowing negative number never uses all four positions.
        if (sign_q && (msd != 2'd3)) fmt_dig[msd + 2'd1] = BCD_NEG;
        if (ovf_q) begin
            fmt_dig[3] = sign_q ? BCD_NEG : BCD_BLANK;
            fmt_dig[2] = BCD_O;
            fmt_dig[1] = BCD_F;
            fmt_dig[0] = BCD_L;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d  = in_sign;
                    mag_d   = abs_val;
                    ovf_d   = in_sign ? (abs_ext > 16'd999) : (abs_ext > 16'd9999);
                    bcd_d   = 16'd0;
                    cnt_d   = 4'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[14:0], mag_q[WIDTH-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = FMT;
            end
            FMT: begin
                dig_d   = fmt_dig;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= 16'd0;
            cnt_q   <= 4'd0;
            dig_q   <= '{default: BCD_BLANK};
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dig3 = dig_q[3];
    assign bus.dig2 = dig_q[2];
    assign bus.dig1 = dig_q[1];
    assign bus.dig0 = dig_q[0];
endmodule

// File: tb/tb_disp_fmt.sv
// Scoreboard bench for disp_fmt: a 15-bit and an 8-bit instance, expected digits
// queued at accept time and compared (digits and latency) when done pulses.
module tb_disp_fmt;
    localparam logic [4:0] BL = 5'h10;
    localparam logic [4:0] NG = 5'h11;
    localparam logic [4:0] LO = 5'h12;
    localparam logic [4:0] LF = 5'h13;
    localparam logic [4:0] LL = 5'h14;

    typedef struct {
        logic [19:0] dig;
        int          acc;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    sb_t  q15[$];
    sb_t  q8[$];
    bit   prev15 = 1'b0;
    bit   prev8 = 1'b0;

    disp_fmt_if #(.WIDTH(15)) bus15 ();
    disp_fmt_if #(.WIDTH(8))  bus8 ();

    disp_fmt #(.WIDTH(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));
    disp_fmt #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference built from decimal arithmetic rather than shift-and-add.
    function automatic logic [19:0] model(input int v);
        int   mag;
        int   top;
        bit   neg;
        logic [4:0] d [4];
        neg = (v < 0);
        mag = neg ? -v : v;
        if ((neg && mag > 999) || (!neg && mag > 9999))
            return {neg ? NG : BL, LO, LF, LL};
        top = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 5'((mag / (10 ** i)) % 10);
            if (d[i] != 5'd0) top = i;
        end
        for (int i = 0; i < 4; i++) if (i > top) d[i] = BL;
        if (neg) d[top + 1] = NG;
        return {d[3], d[2], d[1], d[0]};
    endfunction

    task automatic drive(input bit w8, input int v, input logic [19:0] exp);
        @(negedge clk);
        if (w8) begin
            bus8.start = 1'b1;
            bus8.value = 8'(v);
            q8.push_back('{dig: exp, acc: cyc + 1});
        end else begin
            bus15.start = 1'b1;
            bus15.value = 15'(v);
            q15.push_back('{dig: exp, acc: cyc + 1});
        end
        @(negedge clk);
        bus8.start  = 1'b0;
        bus15.start = 1'b0;
        if (w8) chk("busy8", 32'(bus8.busy), 32'd1);
        else    chk("busy15", 32'(bus15.busy), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q15.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q15.size() + q8.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy15"}, 32'(bus15.busy), 32'd0);
        chk({tag, "_done15"}, 32'(bus15.done), 32'd0);
        chk({tag, "_dig15"}, 32'({bus15.dig3, bus15.dig2, bus15.dig1, bus15.dig0}),
            32'({BL, BL, BL, BL}));
        chk({tag, "_dig8"}, 32'({bus8.dig3, bus8.dig2, bus8.dig1, bus8.dig0}),
            32'({BL, BL, BL, BL}));
    endtask

    always @(negedge clk) begin : mon
        sb_t e;
        if (rst_n) begin
            if (prev15) chk("done_width15", 32'(bus15.done), 32'd0);
            if (prev8)  chk("done_width8", 32'(bus8.done), 32'd0);
            if (bus15.done) begin
                if (q15.size() == 0) chk("spurious_done15", 32'd1, 32'd0);
                else begin
                    e = q15.pop_front();
                    chk("dig15", 32'({bus15.dig3, bus15.dig2, bus15.dig1, bus15.dig0}), 32'(e.dig));
                    chk("lat15", 32'(cyc - e.acc), 32'd16);
                    chk("busy_at_done15", 32'(bus15.busy), 32'd0);
                    $display("txn w15 dig=%h exp=%h lat=%0d", {bus15.dig3, bus15.dig2,
                             bus15.dig1, bus15.dig0}, e.dig, cyc - e.acc);
                end
            end
            if (bus8.done) begin
                if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
                else begin
                    e = q8.pop_front();
                    chk("dig8", 32'({bus8.dig3, bus8.dig2, bus8.dig1, bus8.dig0}), 32'(e.dig));
                    chk("lat8", 32'(cyc - e.acc), 32'd9);
                    $display("txn w8 dig=%h exp=%h lat=%0d", {bus8.dig3, bus8.dig2,
                             bus8.dig1, bus8.dig0}, e.dig, cyc - e.acc);
                end
            end
        end
        prev15 = rst_n && bus15.done;
        prev8  = rst_n && bus8.done;
    end

    int          vals [13] = '{0, 7, 1205, 9999, -5, -40, -999, 10000, -1000, -16384,
                               16383, -1, 1000};
    logic [19:0] exps [13] = '{{BL, BL, BL, 5'd0}, {BL, BL, BL, 5'd7},
                               {5'd1, 5'd2, 5'd0, 5'd5}, {5'd9, 5'd9, 5'd9, 5'd9},
                               {BL, BL, NG, 5'd5}, {BL, NG, 5'd4, 5'd0},
                               {NG, 5'd9, 5'd9, 5'd9}, {BL, LO, LF, LL},
                               {NG, LO, LF, LL}, {NG, LO, LF, LL},
                               {BL, LO, LF, LL}, {BL, BL, NG, 5'd1},
                               {5'd1, 5'd0, 5'd0, 5'd0}};

    initial begin
        int k;
        int r;
        rst_n       = 1'b0;
        bus15.start = 1'b0;
        bus15.value = '0;
        bus8.start  = 1'b0;
        bus8.value  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vals[i]) begin
            drive(1'b0, vals[i], exps[i]);
            drain();
        end

        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 32767));
            if (r >= 16384) r = r - 32768;
            drive(1'b0, r, model(r));
            drain();
        end

        // start pulsed while busy must be dropped, not queued
        drive(1'b0, 7, {BL, BL, BL, 5'd7});
        repeat (3) @(negedge clk);
        bus15.start = 1'b1;
        bus15.value = 15'(9999);
        @(negedge clk);
        bus15.start = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        // value changed right after accept
        @(negedge clk);
        bus15.start = 1'b1;
        bus15.value = 15'(1205);
        q15.push_back('{dig: {5'd1, 5'd2, 5'd0, 5'd5}, acc: cyc + 1});
        @(negedge clk);
        bus15.start = 1'b0;
        bus15.value = 15'(-5);
        drain();

        // start held: re-accepted at the edge after each done pulse
        @(negedge clk);
        bus15.start = 1'b1;
        bus15.value = 15'(-40);
        k = cyc + 1;
        for (int n = 0; n < 3; n++) q15.push_back('{dig: {BL, NG, 5'd4, 5'd0}, acc: k + n * 17});
        while (cyc < k + 34) @(negedge clk);
        bus15.start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        drive(1'b1, -128, {NG, 5'd1, 5'd2, 5'd8});
        drain();
        drive(1'b1, 127, {BL, 5'd1, 5'd2, 5'd7});
        drain();
        drive(1'b1, 0, {BL, BL, BL, 5'd0});
        drain();

        // asynchronous reset in the middle of a conversion
        drive(1'b0, 1205, {5'd1, 5'd2, 5'd0, 5'd5});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        q15.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", 32'(bus15.busy), 32'd0);
        drive(1'b0, 42, {BL, BL, 5'd4, 5'd2});
        drain();
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
